// File: rtl/navegador_menu_pkg.sv
// Shared definitions for the pet menu navigator: FSM state codes and action indices.
// The action indices are the same ones the pet-state block decodes from acao.
package navegador_menu_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    NAVEGA = 2'd1,
    EMITE  = 2'd2
  } estado_t;

  localparam logic [1:0] ACAO_COMER   = 2'd0;
  localparam logic [1:0] ACAO_BRINCAR = 2'd1;
  localparam logic [1:0] ACAO_DORMIR  = 2'd2;
  localparam logic [1:0] ACAO_LIMPAR  = 2'd3;

endpackage

// File: rtl/navegador_menu_contador_timeout.sv
// contador_timeout: idle-cycle counter with synchronous clear and count enable.
// done is high while the count sits at TIMEOUT-1; only built when MENU_TIMEOUT_EN is defined.
module contador_timeout #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/navegador_menu.sv
// navegador_menu: walks a cursor over the pet actions and offers the confirmed one via valid/ack.
// Optional idle auto-close in NAVEGA is built when MENU_TIMEOUT_EN is defined.
module navegador_menu
  import navegador_menu_pkg::*;
#(
  parameter int N_OPCOES = 4,
  parameter int W_OPC    = 2,
  parameter int TIMEOUT  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             b_prox,
  input  logic             b_conf,
  input  logic             b_canc,
  input  logic             ack,
  output logic [W_OPC-1:0] cursor,
  output logic             menu_ativo,
  output logic [W_OPC-1:0] acao,
  output logic             acao_valida
);

  estado_t          estado_q;
  logic [W_OPC-1:0] cursor_q;
  logic [W_OPC-1:0] acao_q;
  logic             acao_valida_q;
  logic             menu_ativo_q;
  logic             expira;

`ifdef MENU_TIMEOUT_EN
  logic pulso;
  logic navega;
  logic timer_done;

  assign pulso  = b_prox | b_conf | b_canc;
  assign navega = (estado_q == NAVEGA);

  // Counter is held at zero outside NAVEGA, restarted by any pulse and on expiry.
  contador_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (!navega || pulso || timer_done),
    .en  (navega && !pulso),
    .done(timer_done)
  );

  assign expira = navega && !pulso && timer_done;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expira         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q      <= OCIOSO;
      cursor_q      <= '0;
      acao_q        <= '0;
      acao_valida_q <= 1'b0;
      menu_ativo_q  <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (b_prox || b_conf) begin
            estado_q     <= NAVEGA;
            menu_ativo_q <= 1'b1;
            cursor_q     <= '0;
          end
        end
        NAVEGA: begin
          // Cancel beats confirm beats next when pulses coincide.
          if (b_canc) begin
            estado_q     <= OCIOSO;
            menu_ativo_q <= 1'b0;
            cursor_q     <= '0;
          end else if (b_conf) begin
            estado_q      <= EMITE;
            acao_q        <= cursor_q;
            acao_valida_q <= 1'b1;
          end else if (b_prox) begin
            cursor_q <= (cursor_q == W_OPC'(N_OPCOES - 1)) ? '0 : cursor_q + 1'b1;
          end else if (expira) begin
            estado_q     <= OCIOSO;
            menu_ativo_q <= 1'b0;
            cursor_q     <= '0;
          end
        end
        EMITE: begin
          if (ack) begin
            estado_q      <= OCIOSO;
            menu_ativo_q  <= 1'b0;
            acao_valida_q <= 1'b0;
            cursor_q      <= '0;
          end
        end
        default: begin
          estado_q      <= OCIOSO;
          menu_ativo_q  <= 1'b0;
          acao_valida_q <= 1'b0;
          cursor_q      <= '0;
        end
      endcase
    end
  end

  assign cursor      = cursor_q;
  assign acao        = acao_q;
  assign acao_valida = acao_valida_q;
  assign menu_ativo  = menu_ativo_q;

endmodule
